// File: rtl/trap_monitor_if.sv
// Commit and report bus of the trap monitor.
// The core side (master) drives commits and the halt acknowledge; the
// monitor (slave) drives the trap status, the halt report and the counters.
interface trap_monitor_if #(
    parameter int NCH  = 2,
    parameter int XLEN = 64
);
    logic [NCH-1:0]      cmt_valid;
    logic [32*NCH-1:0]   cmt_inst;
    logic [XLEN*NCH-1:0] cmt_pc;
    logic [XLEN-1:0]     a0;
    logic                halt_ack;

    logic                trapped;
    logic                halt_valid;
    logic [1:0]          halt_code;
    logic [XLEN-1:0]     halt_pc;
    logic [63:0]         inst_cnt;
    logic [63:0]         cycle_cnt;
    logic                done;

    modport master (
        output cmt_valid, cmt_inst, cmt_pc, a0, halt_ack,
        input  trapped, halt_valid, halt_code, halt_pc, inst_cnt, cycle_cnt, done
    );

    modport slave (
        input  cmt_valid, cmt_inst, cmt_pc, a0, halt_ack,
        output trapped, halt_valid, halt_code, halt_pc, inst_cnt, cycle_cnt, done
    );
endinterface

// File: rtl/trap_monitor.sv
// Simulation trap monitor: watches the commit channels for an ebreak (or a
// long commit-free stretch), latches a halt report, waits a drain period,
// presents the report until acknowledged and then freezes.
module trap_monitor #(
    parameter int NCH       = 2,
    parameter int XLEN      = 64,
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    trap_monitor_if.slave  bus
);

    localparam logic [31:0] EBREAK = 32'h00100073;

    // Idle counter must be able to hold TIMEOUT itself.
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] IDLE_MAX  = '1;
    localparam logic [7:0] DRAIN_LAST   = 8'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            trapped_q;
    logic [1:0]      code_q;
    logic [XLEN-1:0] pc_q;
    logic [63:0]     inst_q;
    logic [63:0]     cycle_q;
    logic [IW-1:0]   idle_q;
    logic [7:0]      drain_q;

    logic            trap_hit;
    logic [XLEN-1:0] trap_pc;
    logic [3:0]      add_cnt;
    logic            any_valid;
    logic            timeout_hit;
    logic            run_active;
    logic            detect;
    logic [64:0]     inst_sum;

    // Scan channels oldest-first: count valid commits up to and including
    // the first ebreak and capture that ebreak's pc.
    always_comb begin
        trap_hit = 1'b0;
        trap_pc  = '0;
        add_cnt  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!trap_hit && bus.cmt_valid[i]) begin
                add_cnt = add_cnt + 4'd1;
                if (bus.cmt_inst[32*i +: 32] == EBREAK) begin
                    trap_hit = 1'b1;
                    trap_pc  = bus.cmt_pc[XLEN*i +: XLEN];
                end
            end
        end
    end

    // RUN with trapped set is the single settle cycle between detection and
    // DRAIN/REPORT; commits are already ignored there.
    assign any_valid   = |bus.cmt_valid;
    assign run_active  = (state == RUN) && !trapped_q;
    assign timeout_hit = (TIMEOUT != 0) && !any_valid && (idle_q == IDLE_LAST);
    assign detect      = run_active && (trap_hit || timeout_hit);
    assign inst_sum    = {1'b0, inst_q} + {61'd0, add_cnt};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE is only left through reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (trapped_q) begin
                    state_next = (DRAIN_CYC == 0) ? REPORT : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (bus.halt_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Drain counter runs 0..DRAIN_CYC-1 while in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= '0;
        end else if (state == DRAIN) begin
            drain_q <= drain_q + 8'd1;
        end else begin
            drain_q <= '0;
        end
    end

    // Latch the halt report once; an ebreak wins over a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trapped_q <= 1'b0;
            code_q    <= 2'd0;
            pc_q      <= '0;
        end else if (detect) begin
            trapped_q <= 1'b1;
            if (trap_hit) begin
                code_q <= (bus.a0 == '0) ? 2'd0 : 2'd1;
                pc_q   <= trap_pc;
            end else begin
                code_q <= 2'd2;
                pc_q   <= '0;
            end
        end
    end

    // Saturating committed-instruction counter, active only while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= '0;
        end else if (run_active) begin
            inst_q <= inst_sum[64] ? '1 : inst_sum[63:0];
        end
    end

    // Cycle counter and idle counter stop only once the report is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            idle_q  <= '0;
        end else if (state != DONE) begin
            cycle_q <= cycle_q + 64'd1;
            if (any_valid) begin
                idle_q <= '0;
            end else if (idle_q != IDLE_MAX) begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

    assign bus.trapped    = trapped_q;
    assign bus.halt_valid = (state == REPORT);
    assign bus.done       = (state == DONE);
    assign bus.halt_code  = code_q;
    assign bus.halt_pc    = pc_q;
    assign bus.inst_cnt   = inst_q;
    assign bus.cycle_cnt  = cycle_q;

endmodule
